// File: rtl/atm_pkg.sv
// Shared types for the ATM bank controller: request opcodes, response
// status codes and controller FSM states.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_INQ = 2'b00,
    OP_WDR = 2'b01,
    OP_DEP = 2'b10,
    OP_XFR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_INSUF   = 2'b01,
    ST_OVF     = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_RESP = 2'b11
  } state_e;

endpackage

// File: rtl/atm_account_bank.sv
// Account balance storage: two combinational read ports, two write ports
// committing on the same edge, every entry loaded with INIT_BAL on reset.
// Out-of-range addresses read as zero and are never written.
module atm_account_bank #(
  parameter int NUM_ACCOUNTS = 16,
  parameter int BAL_W        = 10,
  parameter int INIT_BAL     = 0,
  parameter int ACC_W        = 4,
  parameter bit RD_B_EN      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] rd_addr_a,
  output logic [BAL_W-1:0] rd_data_a,
  input  logic [ACC_W-1:0] rd_addr_b,
  output logic [BAL_W-1:0] rd_data_b,
  input  logic             wr_en_a,
  input  logic [ACC_W-1:0] wr_addr_a,
  input  logic [BAL_W-1:0] wr_data_a,
  input  logic             wr_en_b,
  input  logic [ACC_W-1:0] wr_addr_b,
  input  logic [BAL_W-1:0] wr_data_b
);

  logic [BAL_W-1:0] mem [NUM_ACCOUNTS];

  function automatic logic in_range(input logic [ACC_W-1:0] a);
    return int'(a) < NUM_ACCOUNTS;
  endfunction

  assign rd_data_a = in_range(rd_addr_a) ? mem[rd_addr_a] : '0;
  // Port B folds to constant zero when the controller has no use for it.
  assign rd_data_b = (RD_B_EN && in_range(rd_addr_b)) ? mem[rd_addr_b] : '0;

  // Balance storage with reset preload; both writes land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) mem[i] <= BAL_W'(INIT_BAL);
    end else begin
      if (wr_en_a && in_range(wr_addr_a)) mem[wr_addr_a] <= wr_data_a;
      if (wr_en_b && in_range(wr_addr_b)) mem[wr_addr_b] <= wr_data_b;
    end
  end

endmodule

// File: rtl/atm_bank_ctrl.sv
// ATM bank controller: accepts one request at a time, reads balances,
// executes inquiry/withdraw/deposit/transfer and holds the response until
// consumed. Optional feature macro: ATM_TRANSFER_EN enables op 11
// (transfer); without it op 11 answers ILLEGAL and req_dst is ignored.
module atm_bank_ctrl
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 16,
  parameter int BAL_W        = 10,
  parameter int INIT_BAL     = 0,
  localparam int ACC_W       = (NUM_ACCOUNTS > 2) ? $clog2(NUM_ACCOUNTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ACC_W-1:0] req_src,
  input  logic [ACC_W-1:0] req_dst,
  input  logic [BAL_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [BAL_W-1:0] rsp_balance
);

`ifdef ATM_TRANSFER_EN
  localparam bit XFER_EN = 1'b1;
`else
  localparam bit XFER_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  op_e              op_p0;
  logic [ACC_W-1:0] src_p0;
  logic [BAL_W-1:0] amt_p0;
  logic [BAL_W-1:0] src_bal_p1;
  logic [BAL_W-1:0] rd_data_a, rd_data_b;
  logic [ACC_W-1:0] addr_b;
  logic             commit_a, commit_b, wr_en_a, wr_en_b;
  logic [BAL_W-1:0] wr_data_a, wr_data_b;
  status_e          status_d, status_q;
  logic [BAL_W-1:0] bal_d, bal_q;
  logic             src_in;

`ifdef ATM_TRANSFER_EN
  logic [ACC_W-1:0] dst_p0;
  logic [BAL_W-1:0] dst_bal_p1;
  logic             dst_in;
  assign addr_b = dst_p0;
  assign dst_in = int'(dst_p0) < NUM_ACCOUNTS;
`else
  logic unused_dst;
  assign addr_b     = '0;
  assign unused_dst = ^{rd_data_b, req_dst};
`endif

  function automatic logic add_ovf(input logic [BAL_W-1:0] a,
                                   input logic [BAL_W-1:0] b);
    logic [BAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BAL_W];
  endfunction

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_status  = status_q;
  assign rsp_balance = bal_q;
  assign src_in      = int'(src_p0) < NUM_ACCOUNTS;
  assign wr_en_a     = (state_q == S_EXEC) && commit_a;
  assign wr_en_b     = (state_q == S_EXEC) && commit_b;

  atm_account_bank #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL),
    .ACC_W(ACC_W), .RD_B_EN(XFER_EN)
  ) u_bank (
    .clk(clk), .rst(rst),
    .rd_addr_a(src_p0), .rd_data_a(rd_data_a),
    .rd_addr_b(addr_b), .rd_data_b(rd_data_b),
    .wr_en_a(wr_en_a), .wr_addr_a(src_p0), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(addr_b), .wr_data_b(wr_data_b)
  );

  // FSM state register; reset aborts any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; req_valid outside IDLE is simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 0: latch the request on the accepting edge.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      op_p0  <= op_e'(req_op);
      src_p0 <= req_src;
      amt_p0 <= req_amount;
`ifdef ATM_TRANSFER_EN
      dst_p0 <= req_dst;
`endif
    end
  end

  // Stage 1: register the account balances on the READ->EXEC edge.
  always_ff @(posedge clk) begin
    if (state_q == S_READ) begin
      src_bal_p1 <= rd_data_a;
`ifdef ATM_TRANSFER_EN
      dst_bal_p1 <= rd_data_b;
`endif
    end
  end

  // Execute: decide status, reported balance and which accounts commit.
  // An out-of-range origin reports a zero balance.
  always_comb begin
    status_d  = ST_OK;
    bal_d     = src_bal_p1;
    commit_a  = 1'b0;
    commit_b  = 1'b0;
    wr_data_a = src_bal_p1;
    wr_data_b = '0;
    if (!src_in) begin
      status_d = ST_ILLEGAL;
      bal_d    = '0;
    end else begin
      case (op_p0)
        OP_INQ: status_d = ST_OK;
        OP_WDR: begin
          if (amt_p0 > src_bal_p1) status_d = ST_INSUF;
          else begin
            commit_a  = 1'b1;
            wr_data_a = src_bal_p1 - amt_p0;
            bal_d     = wr_data_a;
          end
        end
        OP_DEP: begin
          if (add_ovf(src_bal_p1, amt_p0)) status_d = ST_OVF;
          else begin
            commit_a  = 1'b1;
            wr_data_a = src_bal_p1 + amt_p0;
            bal_d     = wr_data_a;
          end
        end
        OP_XFR: begin
`ifdef ATM_TRANSFER_EN
          if (!dst_in || dst_p0 == src_p0)       status_d = ST_ILLEGAL;
          else if (amt_p0 > src_bal_p1)          status_d = ST_INSUF;
          else if (add_ovf(dst_bal_p1, amt_p0))  status_d = ST_OVF;
          else begin
            commit_a  = 1'b1;
            commit_b  = 1'b1;
            wr_data_a = src_bal_p1 - amt_p0;
            wr_data_b = dst_bal_p1 + amt_p0;
            bal_d     = wr_data_a;
          end
`else
          status_d = ST_ILLEGAL;
`endif
        end
        default: status_d = ST_ILLEGAL;
      endcase
    end
  end

  // Stage 2: register the response on the EXEC->RESP edge, held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= ST_OK;
      bal_q    <= '0;
    end else if (state_q == S_EXEC) begin
      status_q <= status_d;
      bal_q    <= bal_d;
    end
  end

endmodule

// File: tb/tb_atm_bank_ctrl.sv
// Scoreboard testbench for atm_bank_ctrl (12 accounts, 10-bit balances).
module tb_atm_bank_ctrl;

  localparam int NACC  = 12;
  localparam int BAL_W = 10;
  localparam int ACC_W = 4;
`ifdef ATM_TRANSFER_EN
  localparam bit XF = 1'b1;
`else
  localparam bit XF = 1'b0;
`endif

  localparam logic [1:0] INQ = 2'b00, WDR = 2'b01, DEP = 2'b10, XFR = 2'b11;
  localparam logic [1:0] OK = 2'b00, INS = 2'b01, OVF = 2'b10, ILL = 2'b11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [ACC_W-1:0] req_src = '0;
  logic [ACC_W-1:0] req_dst = '0;
  logic [BAL_W-1:0] req_amount = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [1:0]       rsp_status;
  logic [BAL_W-1:0] rsp_balance;

  atm_bank_ctrl #(.NUM_ACCOUNTS(NACC), .BAL_W(BAL_W), .INIT_BAL(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src(req_src), .req_dst(req_dst), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_balance(rsp_balance)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] st;
    int         bal;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Monitor: every response consumed is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: status=%0d bal=%0d, no response expected",
                 rsp_status, rsp_balance);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_status !== e.st || int'(rsp_balance) !== e.bal) begin
          fails++;
          $display("FAIL %s: got status=%0d bal=%0d, expected status=%0d bal=%0d",
                   e.nm, rsp_status, rsp_balance, e.st, e.bal);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: req_ready=%0d after %0d cycles, expected 1", nm, req_ready, n);
    end
  endtask

  task automatic drive(input logic [1:0] op, input int src, input int dst, input int amt);
    req_op     = op;
    req_src    = ACC_W'(src);
    req_dst    = ACC_W'(dst);
    req_amount = BAL_W'(amt);
  endtask

  task automatic issue(input logic [1:0] op, input int src, input int dst, input int amt,
                       input logic [1:0] est, input int ebal, input string nm);
    exp_t e;
    e.st = est; e.bal = ebal; e.nm = nm;
    sb.push_back(e);
    @(posedge clk); #1;
    drive(op, src, dst, amt);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_idle(nm);
  endtask

  initial begin
    exp_t e;
    int   n;
    // Reset state
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_status", int'(rsp_status), 0);
    chk("rst_rsp_balance", int'(rsp_balance), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Inquiry with latency check: response appears after E+2
    e.st = OK; e.bal = 0; e.nm = "inq3";
    sb.push_back(e);
    @(posedge clk); #1;
    drive(INQ, 3, 0, 77);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("lat_after_E", int'(rsp_valid), 0);
    chk("lat_ready_busy", int'(req_ready), 0);
    @(posedge clk); #1;
    chk("lat_after_E1", int'(rsp_valid), 0);
    @(posedge clk); #1;
    chk("lat_after_E2", int'(rsp_valid), 1);
    wait_idle("inq3");

    // Withdraw / deposit basics
    issue(DEP, 1, 0, 500, OK, 500, "dep500_a1");
    issue(WDR, 1, 0, 500, OK, 0, "wdr500_a1");
    issue(WDR, 1, 0, 1, INS, 0, "wdr1_a1_insuf");

    // Overflow boundary
    issue(DEP, 2, 0, 1000, OK, 1000, "dep1000_a2");
    issue(DEP, 2, 0, 24, OVF, 1000, "dep24_a2_ovf");
    issue(DEP, 2, 0, 23, OK, 1023, "dep23_a2");

    // Transfers
    issue(DEP, 0, 0, 400, OK, 400, "dep400_a0");
    issue(DEP, 5, 0, 800, OK, 800, "dep800_a5");
    issue(DEP, 6, 0, 100, OK, 100, "dep100_a6");
    issue(XFR, 0, 5, 300, XF ? OVF : ILL, 400, "xfr300_0to5");
    issue(XFR, 0, 6, 500, XF ? INS : ILL, 400, "xfr500_0to6");
    issue(XFR, 0, 6, 300, XF ? OK : ILL, XF ? 100 : 400, "xfr300_0to6");
    issue(INQ, 0, 0, 0, OK, XF ? 100 : 400, "inq_a0");
    issue(INQ, 5, 0, 0, OK, 800, "inq_a5");
    issue(INQ, 6, 0, 0, OK, XF ? 400 : 100, "inq_a6");

    // Illegal cases
    issue(XFR, 4, 4, 10, ILL, 0, "xfr_src_eq_dst");
    issue(XFR, 0, 12, 1, ILL, XF ? 100 : 400, "xfr_dst_oob");
    issue(INQ, 12, 0, 0, ILL, 0, "inq_src_oob");
    issue(WDR, 12, 0, 1, ILL, 0, "wdr_src_oob");

    // Zero amounts
    issue(WDR, 2, 0, 0, OK, 1023, "wdr0_a2");
    issue(DEP, 2, 0, 0, OK, 1023, "dep0_a2");

    // Back-pressure: response held stable, new requests ignored
    e.st = OK; e.bal = 1023; e.nm = "inq_a2_stall";
    sb.push_back(e);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive(INQ, 2, 0, 0);
    req_valid = 1'b1;
    @(posedge clk); #1;
    drive(DEP, 2, 0, 5);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", int'(rsp_valid), 1);
      chk("stall_req_ready", int'(req_ready), 0);
      chk("stall_status", int'(rsp_status), int'(OK));
      chk("stall_balance", int'(rsp_balance), 1023);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("inq_a2_stall");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_queued_req", int'(rsp_valid), 0);
    end
    issue(INQ, 2, 0, 0, OK, 1023, "inq_a2_after_stall");

    // Reset during EXEC aborts the deposit and restores INIT_BAL
    @(posedge clk); #1;
    drive(DEP, 7, 0, 100);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_req_ready", int'(req_ready), 1);
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", int'(rsp_valid), 0);
    end
    issue(INQ, 7, 0, 0, OK, 0, "inq_a7_after_rst");
    issue(INQ, 2, 0, 0, OK, 0, "inq_a2_after_rst");
    issue(INQ, 0, 0, 0, OK, 0, "inq_a0_after_rst");

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
